cast_float_to_int_seq: RTL
==========================

Name: cast_float_to_int_seq

Overview:
- Multi-cycle IEEE-754 single-precision to 32-bit integer converter: the float-to-int cast stage of the FPU.
- Consumes floats produced by the int-to-float cast and FPU result bus; returns integers to the integer datapath.
- Rounding is toward zero (C-style truncation). Uses a STEP-bit-per-cycle iterative shifter instead of a full barrel shifter.
- Valid/ready handshake on input and output.

Parameters:
- STEP, 4, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  asynchronous, active-low reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand.
- in  input  32  IEEE-754 single: sign s = in[31], exponent e = in[30:23], mantissa m = in[22:0].
- is_signed  input  1  0 = unsigned result, 1 = signed 2's complement result; sampled at accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  32  integer result.
- invalid  output  1  NaN, Inf or out-of-range; out saturated.
- inexact  output  1  nonzero fraction bits discarded.

Behaviour:
- Reset (clr low, asynchronous): state IDLE; out = 0; out_valid = 0; invalid = 0; inexact = 0; in_ready = 0 while clr low.
- Reset mid-operation: the operation is abandoned and no result is produced. in_ready = 1 on the first cycle after release.
- States: IDLE, SHIFT, NEGATE, DONE.
- IDLE: in_ready = 1. Accept on the clk edge where in_valid & in_ready; latch in and is_signed. Decode with E = e - 127.
- Special cases, accept edge goes directly to DONE:
  - Zero, denormal or E < 0: out = 0; inexact = (in[30:0] != 0); invalid = 0.
  - NaN (e = 255, m != 0): out = signed ? 0x7FFFFFFF : 0xFFFFFFFF; invalid = 1.
  - Signed overflow (E >= 31, or Inf), except s = 1, E = 31, m = 0: out = s ? 0x80000000 : 0x7FFFFFFF; invalid = 1.
  - Unsigned, s = 1, E >= 0 (includes -Inf): out = 0; invalid = 1.
  - Unsigned, E >= 32 (includes +Inf): out = 0xFFFFFFFF; invalid = 1.
- Normal path (all other cases):
  - Accumulator acc = {8'b0, 1, m}; direction = left if E >= 23, else right; count = |E - 23|, range 0..23, max 8 when shifting left.
  - If count = 0, the accept edge goes to NEGATE if (is_signed & s), else to DONE. Otherwise it goes to SHIFT with no shift on that edge.
- SHIFT: each edge shifts acc by min(STEP, remaining) and decrements remaining.
  - Right shifts OR every shifted-out bit into a sticky bit, which becomes inexact.
  - On the edge where remaining <= STEP, go to NEGATE if (is_signed & s), else DONE.
- NEGATE: acc = ~acc + 1 in one cycle, then DONE. The -2^31 case yields 0x80000000 with invalid = 0.
- Unsigned with s = 1 and E < 0: handled as a special case (out = 0; inexact = 1; not invalid).
- Latency (accept edge to out_valid high), normal path: 1 + ceil(count/STEP) + (is_signed & s ? 1 : 0), with the count = 0 case equal to 1 + negate cycle. Special cases: latency 1.
- DONE:
  - out_valid = 1; in_ready = 0.
  - out, invalid and inexact are registered and held stable until out_valid & out_ready, then IDLE on that edge.
  - No back-to-back accept: at most one operand is in flight.
- in_valid is ignored outside IDLE. out, invalid and inexact keep their last values after the handshake.

Test Plan:
- 0x40490FDB (pi), signed, STEP=4 -> out = 0x00000003, inexact = 1, invalid = 0; out_valid 7 edges after accept (count 22, 6 shift cycles).
- 0xC2F60000 (-123.0), signed -> out = 0xFFFFFF85, inexact = 0, invalid = 0; latency 7 (5 shifts + negate).
- 0xCF000000 (-2^31), signed -> out = 0x80000000, invalid = 0, latency 4.
  - 0x4F000000 signed -> 0x7FFFFFFF, invalid = 1, latency 1.
  - 0x4F000000 unsigned -> 0x80000000, invalid = 0.
- 0x7FC00000 (NaN) signed -> 0x7FFFFFFF, invalid = 1.
  - 0xBF000000 (-0.5) unsigned -> 0, inexact = 1, invalid = 0.
  - 0xBF800000 (-1.0) unsigned -> 0, invalid = 1.
  - 0x00000001 (denormal) -> 0, inexact = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> out and flags stable, in_ready = 0, a pulsed in_valid is not accepted. Raise out_ready -> IDLE next edge; next operand converts correctly.
- Drive clr low during SHIFT of pi -> out_valid = 0 and out = 0 immediately without a clock edge. Release clr -> in_ready = 1; converting 0x41200000 (10.0) yields 0x0000000A, inexact = 0.

Source files
------------

// File: rtl/cast_float_to_int_seq_if.sv
// Handshake bus for the float-to-int cast stage: operand in, integer result out.
interface cast_float_to_int_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        invalid;
  logic        inexact;

  modport master (
    output in_valid, in, is_signed, out_ready,
    input  in_ready, out_valid, out, invalid, inexact
  );

  modport slave (
    input  in_valid, in, is_signed, out_ready,
    output in_ready, out_valid, out, invalid, inexact
  );
endinterface

// File: rtl/cast_float_to_int_seq.sv
// IEEE-754 single to 32-bit integer, round toward zero, using a STEP-bit-per-cycle
// iterative shifter. One operand in flight; results held until consumed.
module cast_float_to_int_seq #(
  parameter int unsigned STEP = 4  // 1, 2, 4 or 8
) (
  input  logic                     clk,
  input  logic                     clr,
  cast_float_to_int_seq_if.slave   bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, NEGATE, DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            left_q, left_d;
  logic            neg_q, neg_d;
  logic            sticky_q, sticky_d;
  logic [DW-1:0]   out_q, out_d;
  logic            invalid_q, invalid_d;
  logic            inexact_q, inexact_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic            sgn;
  logic [7:0]      exp8;
  logic [22:0]     man;
  logic            spec_hit;
  logic [DW-1:0]   spec_out;
  logic            spec_inv;
  logic            spec_inx;
  logic            norm_left;
  logic [CW-1:0]   norm_cnt;

  logic [CW-1:0]   step_amt;
  logic [DW-1:0]   mask;
  logic [DW-1:0]   shifted;
  logic            lost;
  logic [DW-1:0]   negated;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.invalid   = invalid_q;
  assign bus.inexact   = inexact_q;

  // Classify the incoming operand; special cases resolve on the accept edge.
  always_comb begin
    sgn      = bus.in[31];
    exp8     = bus.in[30:23];
    man      = bus.in[22:0];
    spec_hit = 1'b1;
    spec_out = '0;
    spec_inv = 1'b0;
    spec_inx = 1'b0;
    if (exp8 == 8'hFF && man != 23'd0) begin
      spec_out = bus.is_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      spec_inv = 1'b1;
    end else if (exp8 < 8'd127) begin
      spec_inx = |bus.in[30:0];
    end else if (bus.is_signed) begin
      // -2^31 exactly is representable and takes the normal path
      if (exp8 >= 8'd158 && !(sgn && exp8 == 8'd158 && man == 23'd0)) begin
        spec_out = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
        spec_inv = 1'b1;
      end else begin
        spec_hit = 1'b0;
      end
    end else if (sgn) begin
      spec_inv = 1'b1;
    end else if (exp8 >= 8'd159) begin
      spec_out = 32'hFFFF_FFFF;
      spec_inv = 1'b1;
    end else begin
      spec_hit = 1'b0;
    end
    norm_left = (exp8 >= 8'd150);
    norm_cnt  = norm_left ? CW'(exp8 - 8'd150) : CW'(8'd150 - exp8);
  end

  // One iteration of the shifter plus the negation datapath.
  always_comb begin
    step_amt = (rem_q <= CW'(STEP)) ? rem_q : CW'(STEP);
    mask     = DW'((33'd1 << step_amt) - 33'd1);
    shifted  = left_q ? (acc_q << step_amt) : (acc_q >> step_amt);
    lost     = !left_q && (|(acc_q & mask));
    negated  = ~acc_q + 32'd1;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    left_d      = left_q;
    neg_d       = neg_q;
    sticky_d    = sticky_q;
    out_d       = out_q;
    invalid_d   = invalid_q;
    inexact_d   = inexact_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          if (spec_hit) begin
            out_d     = spec_out;
            invalid_d = spec_inv;
            inexact_d = spec_inx;
            state_d   = DONE;
          end else begin
            acc_d    = {8'b0, 1'b1, man};
            left_d   = norm_left;
            rem_d    = norm_cnt;
            neg_d    = bus.is_signed & sgn;
            sticky_d = 1'b0;
            if (norm_cnt != '0) begin
              state_d = SHIFT;
            end else if (bus.is_signed & sgn) begin
              state_d = NEGATE;
            end else begin
              out_d     = {8'b0, 1'b1, man};
              invalid_d = 1'b0;
              inexact_d = 1'b0;
              state_d   = DONE;
            end
          end
        end
      end
      SHIFT: begin
        acc_d    = shifted;
        sticky_d = sticky_q | lost;
        rem_d    = rem_q - step_amt;
        if (rem_q <= CW'(STEP)) begin
          if (neg_q) begin
            state_d = NEGATE;
          end else begin
            out_d     = shifted;
            invalid_d = 1'b0;
            inexact_d = sticky_q | lost;
            state_d   = DONE;
          end
        end
      end
      NEGATE: begin
        acc_d     = negated;
        out_d     = negated;
        invalid_d = 1'b0;
        inexact_d = sticky_q;
        state_d   = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      left_q      <= 1'b0;
      neg_q       <= 1'b0;
      sticky_q    <= 1'b0;
      out_q       <= '0;
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      left_q      <= left_d;
      neg_q       <= neg_d;
      sticky_q    <= sticky_d;
      out_q       <= out_d;
      invalid_q   <= invalid_d;
      inexact_q   <= inexact_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
